// File: rtl/out_port_fifo_if.sv
// Consumer-side valid/ready stream for the CPU output-port FIFO.
// master drives the head word; slave accepts it with m_ready.
interface out_port_fifo_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/out_port_fifo.sv
// Buffers CPU OUT-port words and drains them over a valid/ready stream.
// Define OUT_PORT_FIFO_STATS_EN to add words_sent / drop_count counters.
module out_port_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    out_port_fifo_if.master       m,
    output logic [DEPTH_LOG2:0]   level
`ifdef OUT_PORT_FIFO_STATS_EN
    ,
    output logic [15:0]           words_sent,
    output logic [7:0]            drop_count
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int AW    = DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_ACTIVE = 2'd1,
        S_FULL   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  push, pop, drop;
    logic [DATA_WIDTH-1:0] head_nxt;

    assign pop  = m_valid_q & m.m_ready;
    assign push = wr_en & (state_q != S_FULL | pop);
    assign drop = wr_en & (state_q == S_FULL) & ~pop;

    // The new head may be the slot written this very cycle.
    assign head_nxt = (push && wr_ptr_q == rd_ptr_d) ? wr_data
                                                     : mem_q[rd_ptr_d];

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        level_d    = level_q + LW'(push) - LW'(pop);
        overflow_d = overflow_q | drop;
        m_valid_d  = (level_d != '0);
        m_data_d   = m_valid_d ? head_nxt : m_data_q;

        unique case (state_q)
            S_EMPTY: begin
                if (push) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (pop && !push && level_q == LW'(1))
                    state_d = S_EMPTY;
                else if (push && !pop && level_q == LW'(DEPTH - 1))
                    state_d = S_FULL;
            end
            S_FULL: begin
                if (pop && !push) state_d = S_ACTIVE;
            end
            default: state_d = S_EMPTY;
        endcase

        if (flush) begin
            state_d    = S_EMPTY;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            m_valid_d  = 1'b0;
            m_data_d   = m_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; validity is tracked by level/pointers.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    assign full      = (state_q == S_FULL);
    assign empty     = (state_q == S_EMPTY);
    assign overflow  = overflow_q;
    assign level     = level_q;
    assign m.m_valid = m_valid_q;
    assign m.m_data  = m_data_q;

`ifdef OUT_PORT_FIFO_STATS_EN
    logic [15:0] words_sent_q, words_sent_d;
    logic [7:0]  drop_count_q, drop_count_d;

    always_comb begin
        words_sent_d = words_sent_q + 16'(pop);
        drop_count_d = drop_count_q;
        if (drop && drop_count_q != 8'hFF)
            drop_count_d = drop_count_q + 8'd1;
        if (flush) begin
            words_sent_d = '0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_sent_q <= '0;
            drop_count_q <= '0;
        end else begin
            words_sent_q <= words_sent_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign words_sent = words_sent_q;
    assign drop_count = drop_count_q;
`endif
endmodule

// File: tb/tb_out_port_fifo.sv
// Directed bench for out_port_fifo: reset, ordering, overflow,
// simultaneous push/pop, pointer wrap, flush and async reset.
module tb_out_port_fifo;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        flush;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [3:0]  level;
`ifdef OUT_PORT_FIFO_STATS_EN
    logic [15:0] words_sent;
    logic [7:0]  drop_count;
`endif

    int chk = 0;
    int err = 0;

    out_port_fifo_if #(.DATA_WIDTH(16)) bus ();

    out_port_fifo #(
        .DATA_WIDTH(16),
        .DEPTH_LOG2(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (flush),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .m         (bus.master),
        .level     (level)
`ifdef OUT_PORT_FIFO_STATS_EN
        ,
        .words_sent(words_sent),
        .drop_count(drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 16'(i);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0;
        flush = 1'b0; bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(); step();
        chk++; if (empty !== 1'b1) begin err++;
            $display("FAIL reset_empty: got %b exp 1", empty); end
        chk++; if (full !== 1'b0) begin err++;
            $display("FAIL reset_full: got %b exp 0", full); end
        chk++; if (bus.m_valid !== 1'b0) begin err++;
            $display("FAIL reset_valid: got %b exp 0", bus.m_valid); end
        chk++; if (level !== 4'd0) begin err++;
            $display("FAIL reset_level: got %0d exp 0", level); end
        chk++; if (bus.m_data !== 16'h0000) begin err++;
            $display("FAIL reset_data: got %h exp 0000", bus.m_data); end
        chk++; if (overflow !== 1'b0) begin err++;
            $display("FAIL reset_ovf: got %b exp 0", overflow); end
    endtask

    task automatic test_single();
        push_words(1, 16'h1234);
        chk++; if (bus.m_valid !== 1'b1) begin err++;
            $display("FAIL single_valid: got %b exp 1", bus.m_valid); end
        chk++; if (bus.m_data !== 16'h1234) begin err++;
            $display("FAIL single_data: got %h exp 1234", bus.m_data); end
        chk++; if (level !== 4'd1) begin err++;
            $display("FAIL single_level: got %0d exp 1", level); end
        for (int i = 0; i < 5; i++) begin
            step();
            chk++;
            if (bus.m_data !== 16'h1234 || bus.m_valid !== 1'b1) begin
                err++;
                $display("FAIL single_hold%0d: got %b/%h exp 1/1234",
                         i, bus.m_valid, bus.m_data);
            end
        end
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk++; if (empty !== 1'b1 || level !== 4'd0) begin err++;
            $display("FAIL single_drain: got empty=%b level=%0d exp 1/0",
                     empty, level); end
        chk++; if (bus.m_valid !== 1'b0) begin err++;
            $display("FAIL single_valid0: got %b exp 0", bus.m_valid); end
    endtask

    task automatic test_fill_overflow();
        push_words(8, 16'h0001);
        chk++; if (full !== 1'b1 || level !== 4'd8) begin err++;
            $display("FAIL fill_full: got full=%b level=%0d exp 1/8",
                     full, level); end
        chk++; if (overflow !== 1'b0) begin err++;
            $display("FAIL fill_ovf0: got %b exp 0", overflow); end
        push_words(1, 16'h0009);
        chk++; if (level !== 4'd8 || overflow !== 1'b1) begin err++;
            $display("FAIL fill_drop: got level=%0d ovf=%b exp 8/1",
                     level, overflow); end
`ifdef OUT_PORT_FIFO_STATS_EN
        chk++; if (drop_count !== 8'd1) begin err++;
            $display("FAIL fill_dropcnt: got %0d exp 1", drop_count); end
`endif
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== 16'(i)) begin
                err++;
                $display("FAIL fill_order%0d: got %b/%h exp 1/%h",
                         i, bus.m_valid, bus.m_data, 16'(i));
            end
            step();
        end
        bus.m_ready = 1'b0;
        chk++; if (empty !== 1'b1 || bus.m_valid !== 1'b0) begin err++;
            $display("FAIL fill_nine: got empty=%b valid=%b exp 1/0",
                     empty, bus.m_valid); end
        chk++; if (overflow !== 1'b1) begin err++;
            $display("FAIL fill_sticky: got %b exp 1", overflow); end
`ifdef OUT_PORT_FIFO_STATS_EN
        chk++; if (words_sent !== 16'd9) begin err++;
            $display("FAIL fill_sent: got %0d exp 9", words_sent); end
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk++; if (overflow !== 1'b0) begin err++;
            $display("FAIL fill_flush_ovf: got %b exp 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp;
        push_words(8, 16'h0001);
        wr_en = 1'b1; wr_data = 16'h00AA; bus.m_ready = 1'b1;
        step();
        wr_en = 1'b0;
        chk++; if (level !== 4'd8 || full !== 1'b1) begin err++;
            $display("FAIL pp_level: got level=%0d full=%b exp 8/1",
                     level, full); end
        chk++; if (overflow !== 1'b0) begin err++;
            $display("FAIL pp_ovf: got %b exp 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            exp = (i == 7) ? 16'h00AA : 16'(i + 2);
            chk++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp) begin
                err++;
                $display("FAIL pp_order%0d: got %b/%h exp 1/%h",
                         i, bus.m_valid, bus.m_data, exp);
            end
            step();
        end
        bus.m_ready = 1'b0;
        chk++; if (empty !== 1'b1) begin err++;
            $display("FAIL pp_empty: got %b exp 1", empty); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp;
        push_words(3, 16'h0100);
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_data = 16'h0103 + 16'(i);
            bus.m_ready = 1'b1;
            exp = 16'h0100 + 16'(i);
            chk++;
            if (bus.m_data !== exp) begin
                err++;
                $display("FAIL wrap_data%0d: got %h exp %h",
                         i, bus.m_data, exp);
            end
            step();
            chk++;
            if (level !== 4'd3) begin
                err++;
                $display("FAIL wrap_level%0d: got %0d exp 3", i, level);
            end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = 16'h0114 + 16'(i);
            chk++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp) begin
                err++;
                $display("FAIL wrap_tail%0d: got %b/%h exp 1/%h",
                         i, bus.m_valid, bus.m_data, exp);
            end
            step();
        end
        bus.m_ready = 1'b0;
        chk++; if (empty !== 1'b1) begin err++;
            $display("FAIL wrap_empty: got %b exp 1", empty); end
    endtask

    task automatic test_flush_reset();
        push_words(9, 16'h0200);
        bus.m_ready = 1'b1;
        repeat (3) step();
        bus.m_ready = 1'b0;
        chk++; if (level !== 4'd5 || overflow !== 1'b1) begin err++;
            $display("FAIL fr_pre: got level=%0d ovf=%b exp 5/1",
                     level, overflow); end
        flush = 1'b1; wr_en = 1'b1; wr_data = 16'hBEEF;
        step();
        flush = 1'b0; wr_en = 1'b0;
        chk++; if (level !== 4'd0 || empty !== 1'b1) begin err++;
            $display("FAIL fr_flush: got level=%0d empty=%b exp 0/1",
                     level, empty); end
        chk++; if (overflow !== 1'b0 || bus.m_valid !== 1'b0) begin err++;
            $display("FAIL fr_flush2: got ovf=%b valid=%b exp 0/0",
                     overflow, bus.m_valid); end
`ifdef OUT_PORT_FIFO_STATS_EN
        chk++; if (words_sent !== 16'd0) begin err++;
            $display("FAIL fr_sent_flush: got %0d exp 0", words_sent); end
`endif
        push_words(2, 16'h0300);
        chk++; if (level !== 4'd2 || bus.m_data !== 16'h0300) begin err++;
            $display("FAIL fr_refill: got level=%0d data=%h exp 2/0300",
                     level, bus.m_data); end
        #3 rst_n = 1'b0;
        #1;
        chk++; if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0)
        begin err++;
            $display("FAIL fr_rst: got level=%0d empty=%b full=%b exp 0/1/0",
                     level, empty, full); end
        chk++; if (bus.m_valid !== 1'b0 || bus.m_data !== 16'h0000 ||
                   overflow !== 1'b0) begin err++;
            $display("FAIL fr_rst2: got valid=%b data=%h ovf=%b exp 0/0000/0",
                     bus.m_valid, bus.m_data, overflow); end
`ifdef OUT_PORT_FIFO_STATS_EN
        chk++; if (words_sent !== 16'd0) begin err++;
            $display("FAIL fr_sent_rst: got %0d exp 0", words_sent); end
`endif
        step();
        rst_n = 1'b1;
        step();
        chk++; if (empty !== 1'b1 || bus.m_valid !== 1'b0) begin err++;
            $display("FAIL fr_post: got empty=%b valid=%b exp 1/0",
                     empty, bus.m_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule
